// File: rtl/music_pkg.sv
// Shared types and constants for the music sequencer: state encoding,
// note byte layout and duration-code-to-milliseconds mapping.
package music_pkg;

  localparam int unsigned TONE_W = 5;
  localparam int unsigned DUR_W  = 3;
  localparam int unsigned NOTE_W = TONE_W + DUR_W;
  localparam int unsigned CNT_W  = 16;

  localparam logic [CNT_W-1:0] DUR_MS_1 = 16'd200;
  localparam logic [CNT_W-1:0] DUR_MS_2 = 16'd500;
  localparam logic [CNT_W-1:0] DUR_MS_3 = 16'd1000;
  localparam logic [CNT_W-1:0] DUR_MS_4 = 16'd2000;
  localparam logic [CNT_W-1:0] DUR_MS_5 = 16'd4000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [TONE_W-1:0] tone;
    logic [DUR_W-1:0]  dur;
  } note_t;

  // Unlisted codes (and 0, which never reaches the queue) fall back to the shortest note
  function automatic logic [CNT_W-1:0] dur_to_ms(input logic [DUR_W-1:0] code);
    case (code)
      3'd2:    return DUR_MS_2;
      3'd3:    return DUR_MS_3;
      3'd4:    return DUR_MS_4;
      3'd5:    return DUR_MS_5;
      default: return DUR_MS_1;
    endcase
  endfunction

endpackage

// File: rtl/music_seq_ctrl_if.sv
// UART-side note input and tone-generator-side status bundle.
interface music_seq_ctrl_if;
  import music_pkg::*;

  logic              uart_done;
  logic [NOTE_W-1:0] uart_recv_data;
  logic [TONE_W-1:0] music_tone;
  logic              busy;
  logic              fifo_full;
  logic              overflow;

  modport master (
    output uart_done, uart_recv_data,
    input  music_tone, busy, fifo_full, overflow
  );

  modport slave (
    input  uart_done, uart_recv_data,
    output music_tone, busy, fifo_full, overflow
  );
endinterface

// File: rtl/note_fifo.sv
// Synchronous note queue; head word is always presented on rd_data from storage flops.
module note_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  // A pop frees the slot a same-cycle push needs, so push is accepted when full and popping
  always_comb begin
    do_push  = push && !flush && (!full_q || pop);
    do_pop   = pop && !flush && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/music_seq_ctrl.sv
// Note sequencer: queues UART note bytes and plays them with timed durations and
// gaps, or passes tones straight through in live mode.
module music_seq_ctrl
  import music_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned GAP_MS     = 20
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          tick_1ms,
  input  logic          mode_live,
  music_seq_ctrl_if.slave bus
);

  localparam int unsigned      CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(GAP_MS);

  state_e            state_q, state_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  note_t             note_q, note_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              uart_done_q, mode_q;

  note_t             rx_note, fifo_head;
  logic              push, is_stop, mode_chg, note_push, flush, pop;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign rx_note   = bus.uart_recv_data;
  assign push      = bus.uart_done & ~uart_done_q;
  assign mode_chg  = mode_live ^ mode_q;
  assign is_stop   = push && !mode_live && !mode_chg && (rx_note.dur == '0);
  assign note_push = push && !mode_live && !mode_chg && (rx_note.dur != '0);
  assign flush     = mode_chg || is_stop;

  note_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (NOTE_W)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .push    (note_push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (rx_note),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next-state and output logic; mode change and STOP override the sequencer
  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      tone_d  = '0;
      cnt_d   = '0;
    end else if (mode_live) begin
      state_d = ST_IDLE;
      if (push) tone_d = rx_note.tone;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tone_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            note_d  = fifo_head;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          tone_d  = note_q.tone;
          cnt_d   = dur_to_ms(note_q.dur);
          state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (tick_1ms) begin
            if (cnt_q == CNT_W'(1)) begin
              tone_d = '0;
              if (GAP_MS != 0) begin
                cnt_d   = GAP_CNT;
                state_d = ST_GAP;
              end else if (!fifo_empty) begin
                pop     = 1'b1;
                note_d  = fifo_head;
                state_d = ST_LOAD;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (tick_1ms) begin
            if (cnt_q == CNT_W'(1)) begin
              if (!fifo_empty) begin
                pop     = 1'b1;
                note_d  = fifo_head;
                state_d = ST_LOAD;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d     = (state_d == ST_PLAY) || (state_d == ST_GAP);
    overflow_d = note_push && (fifo_count == CW'(FIFO_DEPTH)) && !pop;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      tone_q      <= '0;
      cnt_q       <= '0;
      note_q      <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      uart_done_q <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tone_q      <= tone_d;
      cnt_q       <= cnt_d;
      note_q      <= note_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      uart_done_q <= bus.uart_done;
      mode_q      <= mode_live;
    end
  end

  assign bus.music_tone = tone_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Directed bench for music_seq_ctrl: queued playback timing, STOP, queue full/overflow,
// live mode, edge detection, reset and mode switching.
module tb_music_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic mode_live;

  music_seq_ctrl_if bus_if ();

  music_seq_ctrl #(
    .FIFO_DEPTH (16),
    .GAP_MS     (20)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .tick_1ms  (tick),
    .mode_live (mode_live),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus_if.uart_recv_data = b;
    bus_if.uart_done      = 1'b1;
    cyc(1);
    bus_if.uart_done      = 1'b0;
    cyc(1);
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  initial begin
    int bad;
    logic [4:0] t;

    rst                   = 1'b1;
    tick                  = 1'b0;
    mode_live             = 1'b0;
    bus_if.uart_done      = 1'b0;
    bus_if.uart_recv_data = 8'h00;
    cyc(2);
    chk("rst_tone", bus_if.music_tone, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_full", bus_if.fifo_full, 0);
    chk("rst_ovf",  bus_if.overflow, 0);
    rst = 1'b0;
    cyc(1);

    // Single 200 ms note followed by 20 ms gap
    send(8'h51);
    cyc(1);
    chk("q_tone_start", bus_if.music_tone, 10);
    chk("q_busy_play",  bus_if.busy, 1);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus_if.music_tone !== 5'd10) bad++;
      tick_pulse();
    end
    chk("q_tone_held_200", bad, 0);
    chk("q_tone_gap", bus_if.music_tone, 0);
    chk("q_busy_gap", bus_if.busy, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.music_tone !== 5'd0 || bus_if.busy !== 1'b1) bad++;
      tick_pulse();
    end
    chk("q_gap_20", bad, 0);
    chk("q_busy_idle", bus_if.busy, 0);

    // STOP flushes a queued note and silences the playing one
    send(8'h31);
    cyc(8);
    chk("stop_pre_tone", bus_if.music_tone, 6);
    send(8'h42);
    cyc(8);
    bus_if.uart_recv_data = 8'h00;
    bus_if.uart_done      = 1'b1;
    cyc(1);
    chk("stop_tone", bus_if.music_tone, 0);
    chk("stop_busy", bus_if.busy, 0);
    bus_if.uart_done = 1'b0;
    cyc(10);
    chk("stop_no_play_tone", bus_if.music_tone, 0);
    chk("stop_no_play_busy", bus_if.busy, 0);

    // Fill queue during a 4000 ms note, overflow on the 17th byte
    send(8'h1D);
    cyc(1);
    chk("fill_long_tone", bus_if.music_tone, 3);
    for (int i = 0; i < 16; i++) begin
      t = 5'(i + 4);
      send({t, 3'b001});
    end
    chk("fill_full", bus_if.fifo_full, 1);
    chk("fill_no_ovf", bus_if.overflow, 0);
    bus_if.uart_recv_data = 8'hF9;
    bus_if.uart_done      = 1'b1;
    cyc(1);
    chk("ovf_pulse", bus_if.overflow, 1);
    bus_if.uart_done = 1'b0;
    cyc(1);
    chk("ovf_clear", bus_if.overflow, 0);
    chk("fill_still_playing", bus_if.music_tone, 3);
    for (int i = 0; i < 4020; i++) tick_pulse();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("order_%0d", i), bus_if.music_tone, 32'(i + 4));
      if (i == 0) chk("full_clear_after_pop", bus_if.fifo_full, 0);
      for (int k = 0; k < 220; k++) tick_pulse();
    end
    chk("drain_tone", bus_if.music_tone, 0);
    chk("drain_busy", bus_if.busy, 0);

    // Live mode pass-through
    mode_live = 1'b1;
    cyc(1);
    chk("live_enter_tone", bus_if.music_tone, 0);
    bus_if.uart_recv_data = 8'h68;
    bus_if.uart_done      = 1'b1;
    cyc(1);
    chk("live_tone_13", bus_if.music_tone, 13);
    chk("live_busy", bus_if.busy, 0);
    bus_if.uart_done = 1'b0;
    cyc(1);
    for (int i = 0; i < 5; i++) tick_pulse();
    cyc(30);
    chk("live_hold_13", bus_if.music_tone, 13);
    bus_if.uart_recv_data = 8'h70;
    bus_if.uart_done      = 1'b1;
    cyc(1);
    chk("live_tone_14", bus_if.music_tone, 14);
    bus_if.uart_done = 1'b0;
    cyc(50);
    chk("live_hold_14", bus_if.music_tone, 14);
    for (int i = 0; i < 20; i++) send(8'h89);
    chk("live_last_tone", bus_if.music_tone, 17);
    chk("live_no_queue_full", bus_if.fifo_full, 0);
    chk("live_no_ovf", bus_if.overflow, 0);
    mode_live = 1'b0;
    cyc(1);
    chk("live_exit_tone", bus_if.music_tone, 0);
    cyc(10);
    chk("live_exit_idle_tone", bus_if.music_tone, 0);
    chk("live_exit_idle_busy", bus_if.busy, 0);

    // Long uart_done level gives one push only
    bus_if.uart_recv_data = 8'h21;
    bus_if.uart_done      = 1'b1;
    cyc(50);
    bus_if.uart_done = 1'b0;
    cyc(1);
    chk("edge_first_tone", bus_if.music_tone, 4);
    send(8'h29);
    for (int i = 0; i < 220; i++) tick_pulse();
    chk("edge_single_push", bus_if.music_tone, 5);

    // Reset mid-PLAY
    send(8'h31);
    for (int i = 0; i < 3; i++) tick_pulse();
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_tone", bus_if.music_tone, 0);
    chk("rst_mid_busy", bus_if.busy, 0);
    chk("rst_mid_full", bus_if.fifo_full, 0);
    chk("rst_mid_ovf",  bus_if.overflow, 0);
    rst = 1'b0;
    cyc(5);
    chk("rst_queue_empty_tone", bus_if.music_tone, 0);
    chk("rst_queue_empty_busy", bus_if.busy, 0);

    // Entering live mode with queued notes flushes everything
    send(8'h1D);
    for (int i = 0; i < 5; i++) send(8'h21);
    chk("ml_pre_busy", bus_if.busy, 1);
    chk("ml_pre_tone", bus_if.music_tone, 3);
    mode_live = 1'b1;
    cyc(1);
    chk("ml_tone", bus_if.music_tone, 0);
    chk("ml_busy", bus_if.busy, 0);
    mode_live = 1'b0;
    cyc(5);
    chk("ml_flushed_tone", bus_if.music_tone, 0);
    chk("ml_flushed_busy", bus_if.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/music_seq_ctrl.md
MUSIC_SEQ_CTRL -- requirements
Module: music_seq_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, giving the note queue depth (power of 2, 4..64).
REQ-002 SHALL have parameter GAP_MS, default 20, giving the silent gap in ms after each queued note (0 = no gap).
REQ-003 SHALL have port sys_clk  input  1  system clock (50 MHz); single clock domain.
REQ-004 SHALL have port sys_rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port tick_1ms  input  1  one-cycle sys_clk-domain strobe, once per ms.
REQ-006 SHALL have port mode_live  input  1  0 = queued playback, 1 = live (immediate) playback.
REQ-007 SHALL have port uart_done  input  1  UART byte-valid level; block detects its rising edge.
REQ-008 SHALL have port uart_recv_data  input  8  note byte: [7:3] tone code, [2:0] duration code.
REQ-009 SHALL have port music_tone  output  5  tone code to the tone generator; 0 = silence.
REQ-010 SHALL have port busy  output  1  high while in PLAY or GAP.
REQ-011 SHALL have port fifo_full  output  1  note queue full.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse when a byte is dropped on a full queue.

Function
REQ-013 SHALL register uart_done once and generate push = uart_done & ~uart_done_q (one push per rising edge).
REQ-014 SHALL map duration code: 1->200, 2->500, 3->1000, 4->2000, 5->4000 ms; codes 6, 7 -> 200 ms.
REQ-015 SHALL treat, in queued mode, duration code 0 as STOP: flush queue, music_tone <= 0, state <= IDLE, next cycle.
REQ-016 SHALL, in queued mode, push non-STOP bytes into the queue; push when full drops the byte and pulses overflow.
REQ-017 SHALL implement states IDLE, LOAD, PLAY, GAP.
REQ-018 IDLE: music_tone = 0; queue non-empty -> pop, go LOAD.
REQ-019 LOAD (one cycle): music_tone <= popped tone, duration counter <= mapped ms, go PLAY; tone visible 2 cycles after IDLE sees non-empty.
REQ-020 PLAY: decrement counter on each tick_1ms; tick with counter == 1 -> music_tone <= 0, counter <= GAP_MS, go GAP (go IDLE/LOAD directly if GAP_MS = 0).
REQ-021 GAP: decrement on tick; tick with counter == 1 -> queue non-empty ? pop and LOAD : IDLE.
REQ-022 Tone code 0 in queued mode SHALL be a rest of the given duration, sequenced like any note.
REQ-023 Simultaneous push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-024 Live mode: each pushed byte sets music_tone <= [7:3] the next cycle, duration ignored, tone held until next byte; queue not written.
REQ-025 mode_live 0->1 SHALL flush queue, go IDLE, music_tone <= 0 in one cycle; 1->0 SHALL set music_tone <= 0, go IDLE.
REQ-026 Counters SHALL be 16 bits; tick_1ms in LOAD is ignored (duration counting starts in PLAY).

Reset
REQ-027 sys_rst SHALL force state IDLE, queue empty, counters 0, uart_done_q 0, music_tone 0, busy 0, fifo_full 0, overflow 0.
REQ-028 Reset asserted mid-note SHALL silence output on the next clock edge and discard queued notes.

Structure
REQ-029 Shared package music_pkg SHALL hold the state enum, tone/duration field widths, and duration-code-to-ms constants.
REQ-030 Queue SHALL be sub-module note_fifo (synchronous, first-word registered, flush input, full/empty, count).
REQ-031 Target 150-300 lines RTL total; no latches, no second clock.

Verification
REQ-032 Queued: push 0x51 (tone 10, 200 ms) -> music_tone = 10 for exactly 200 ticks, 0 for 20 ticks, busy drops, IDLE.
REQ-033 Queued: push 0x31,0x42,0x00 spaced 10 cycles -> STOP flushes; music_tone = 0 next cycle, no note plays.
REQ-034 Fill 16 bytes during a 4000 ms note, push 17th -> fifo_full = 1, one overflow pulse, all 16 later play in order.
REQ-035 Live: push 0x68 then 0x70 -> music_tone = 13 then 14, each one cycle after its uart_done edge; held indefinitely.
REQ-036 uart_done high 50 cycles -> exactly one push; sys_rst pulsed mid-PLAY -> all outputs 0 next cycle, queue empty.
REQ-037 Toggle mode_live 0->1 with 5 queued notes -> queue empty, music_tone = 0, busy = 0 next cycle.
